ibex_irq_ctrl: RTL and testbench

Parametrised interrupt controller between the core's interrupt pins and the Ibex controller/CSR file. Samples software, timer, external, up to 15 fast interrupts and NMI; keeps a registered mip image; arbitrates by fixed priority; presents one request with an `exc_cause_e`-encoded cause over a req/ack handshake. Successor to the fixed 15-fast-IRQ `irqs_t` handling: fast-IRQ count is a parameter and NMI nesting protection is added.

---
 rtl/ibex_irq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ibex_irq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_irq_ctrl.sv
// ibex_irq_ctrl: samples core interrupt pins into a registered mip image,
// picks one eligible source by fixed priority and offers it to the controller
// over a req/ack handshake. NMI nesting is blocked with nmi_mode.
// Optional feature macro: IBEX_IRQ_FAST_EDGE_EN (rising-edge latched fast IRQs).
module ibex_irq_ctrl #(
   parameter int unsigned NumFastIrq = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  irq_software_i,
   input  logic                  irq_timer_i,
   input  logic                  irq_external_i,
   input  logic [NumFastIrq-1:0] irq_fast_i,
   input  logic                  irq_nm_i,
   input  logic                  csr_mstatus_mie_i,
   input  logic [31:0]           csr_mie_i,
   input  logic                  debug_mode_i,
   input  logic                  irq_ack_i,
   input  logic                  nmi_done_i,
   output logic [31:0]           csr_mip_o,
   output logic                  irq_req_o,
   output logic [5:0]            irq_cause_o,
   output logic                  nmi_mode_o
);

   localparam int unsigned MipW     = 32;
   localparam int unsigned CauseW   = 6;
   localparam int unsigned FastBase = 16;
   localparam int unsigned FastIdxW = (NumFastIrq > 1) ? $clog2(NumFastIrq) : 1;

   localparam logic [CauseW-1:0] CauseNmi   = 6'h3F;
   localparam logic [CauseW-1:0] CauseExt   = 6'h2B;
   localparam logic [CauseW-1:0] CauseSw    = 6'h23;
   localparam logic [CauseW-1:0] CauseTimer = 6'h27;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACKD = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CauseW-1:0]   cause_q, cause_d;
   logic                req_q;
   logic [MipW-1:0]     mip_q, mip_d;
   logic [MipW-1:0]     elig;
   logic [NumFastIrq-1:0] elig_fast;
   logic [NumFastIrq-1:0] fast_next;
   logic                nmi_prev_q;
   logic                nmi_pend_q, nmi_pend_d;
   logic                nmi_mode_q, nmi_mode_d;
   logic                nmi_elig;
   logic                ack_take;
   logic                ack_nmi;
   logic                fast_hit;
   logic [CauseW-1:0]   fast_cause;
   logic                win_valid;
   logic [CauseW-1:0]   win_cause;

`ifdef IBEX_IRQ_FAST_EDGE_EN
   logic [NumFastIrq-1:0] fast_prev_q;
   logic [NumFastIrq-1:0] fast_clr;

   // Clear only the latch of the fast source being acknowledged
   always_comb begin
      fast_clr = '0;
      if (ack_take && cause_q[4] && (cause_q != CauseNmi)) begin
         fast_clr = NumFastIrq'(1) << cause_q[3:0];
      end
   end

   // Rising edge sets the sticky latch; a coincident edge beats the clear
   assign fast_next = (irq_fast_i & ~fast_prev_q) |
                      (mip_q[FastBase +: NumFastIrq] & ~fast_clr);

   // Fast IRQ edge history
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fast_prev_q <= '0;
      end else begin
         fast_prev_q <= irq_fast_i;
      end
   end
`else
   assign fast_next = irq_fast_i;
`endif

   // Next pending image; unused bits stay zero
   always_comb begin
      mip_d                          = '0;
      mip_d[3]                       = irq_software_i;
      mip_d[7]                       = irq_timer_i;
      mip_d[11]                      = irq_external_i;
      mip_d[FastBase +: NumFastIrq]  = fast_next;
   end

   // Eligibility gated by enables and debug mode
   always_comb begin
      elig      = mip_q & csr_mie_i & {MipW{csr_mstatus_mie_i}} & {MipW{~debug_mode_i}};
      elig_fast = elig[FastBase +: NumFastIrq];
      nmi_elig  = nmi_pend_q & ~nmi_mode_q & ~debug_mode_i;
   end

   // Fixed-priority arbiter: NMI, fast[0..N-1], external, software, timer
   always_comb begin
      fast_hit   = 1'b0;
      fast_cause = '0;
      for (int unsigned i = 0; i < NumFastIrq; i++) begin
         if (elig_fast[FastIdxW'(i)] && !fast_hit) begin
            fast_hit   = 1'b1;
            fast_cause = {1'b1, 5'(FastBase + i)};
         end
      end
      win_valid = 1'b1;
      win_cause = '0;
      if (nmi_elig) begin
         win_cause = CauseNmi;
      end else if (fast_hit) begin
         win_cause = fast_cause;
      end else if (elig[11]) begin
         win_cause = CauseExt;
      end else if (elig[3]) begin
         win_cause = CauseSw;
      end else if (elig[7]) begin
         win_cause = CauseTimer;
      end else begin
         win_valid = 1'b0;
      end
   end

   // Handshake FSM next state; cause bits [4:0] equal the mip bit index
   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      ack_take = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = REQ;
               cause_d = win_cause;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               state_d  = ACKD;
               ack_take = 1'b1;
            end else if ((cause_q != CauseNmi) && !elig[cause_q[4:0]]) begin
               state_d = IDLE;
            end
         end
         ACKD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NMI bookkeeping; an ack of the NMI wins over a coincident nmi_done
   always_comb begin
      ack_nmi    = ack_take && (cause_q == CauseNmi);
      nmi_pend_d = (irq_nm_i & ~nmi_prev_q) | (nmi_pend_q & ~ack_nmi);
      nmi_mode_d = ack_nmi | (nmi_mode_q & ~nmi_done_i);
   end

   // State, pending image and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cause_q    <= '0;
         req_q      <= 1'b0;
         mip_q      <= '0;
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
         nmi_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         req_q      <= (state_d == REQ);
         mip_q      <= mip_d;
         nmi_prev_q <= irq_nm_i;
         nmi_pend_q <= nmi_pend_d;
         nmi_mode_q <= nmi_mode_d;
      end
   end

   assign csr_mip_o   = mip_q;
   assign irq_req_o   = req_q;
   assign irq_cause_o = cause_q;
   assign nmi_mode_o  = nmi_mode_q;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Directed self-checking bench for ibex_irq_ctrl.
module tb_ibex_irq_ctrl;

`ifdef IBEX_IRQ_FAST_EDGE_EN
   localparam int unsigned NF = 4;
`else
   localparam int unsigned NF = 15;
`endif

   logic          clk;
   logic          rst;
   logic          irq_software;
   logic          irq_timer;
   logic          irq_external;
   logic [NF-1:0] irq_fast;
   logic          irq_nm;
   logic          mstatus_mie;
   logic [31:0]   mie;
   logic          debug_mode;
   logic          irq_ack;
   logic          nmi_done;
   logic [31:0]   csr_mip;
   logic          irq_req;
   logic [5:0]    irq_cause;
   logic          nmi_mode;

   int errors = 0;
   int checks = 0;

   ibex_irq_ctrl #(.NumFastIrq(NF)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .irq_software_i    (irq_software),
      .irq_timer_i       (irq_timer),
      .irq_external_i    (irq_external),
      .irq_fast_i        (irq_fast),
      .irq_nm_i          (irq_nm),
      .csr_mstatus_mie_i (mstatus_mie),
      .csr_mie_i         (mie),
      .debug_mode_i      (debug_mode),
      .irq_ack_i         (irq_ack),
      .nmi_done_i        (nmi_done),
      .csr_mip_o         (csr_mip),
      .irq_req_o         (irq_req),
      .irq_cause_o       (irq_cause),
      .nmi_mode_o        (nmi_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0;
      irq_fast = '0; irq_nm = 1'b0; mstatus_mie = 1'b0; mie = '0;
      debug_mode = 1'b0; irq_ack = 1'b0; nmi_done = 1'b0;
      step(2);
      checks++; if (csr_mip !== 32'h0) begin errors++; $display("FAIL reset_mip: got %h exp %h", csr_mip, 32'h0); end
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", irq_req); end
      checks++; if (irq_cause !== 6'h00) begin errors++; $display("FAIL reset_cause: got %h exp 00", irq_cause); end
      checks++; if (nmi_mode !== 1'b0) begin errors++; $display("FAIL reset_nmi_mode: got %b exp 0", nmi_mode); end
      rst = 1'b0;
      step(2);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL post_reset_req: got %b exp 0", irq_req); end
   endtask

   task automatic test_timer;
      mstatus_mie = 1'b1; mie = 32'h0000_0080;
      irq_timer = 1'b1;
      step(1);
      checks++; if (csr_mip !== 32'h0000_0080) begin errors++; $display("FAIL timer_mip: got %h exp %h", csr_mip, 32'h80); end
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL timer_req_early: got %b exp 0", irq_req); end
      step(1);
      checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL timer_req: got %b exp 1", irq_req); end
      checks++; if (irq_cause !== 6'h27) begin errors++; $display("FAIL timer_cause: got %h exp 27", irq_cause); end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0; irq_timer = 1'b0;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL timer_ack_drop: got %b exp 0", irq_req); end
      step(2);
   endtask

   task automatic test_priority;
      mstatus_mie = 1'b1; mie = 32'h0004_0808;
      irq_external = 1'b1; irq_fast[2] = 1'b1; irq_software = 1'b1;
      step(2);
      checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL prio_req1: got %b exp 1", irq_req); end
      checks++; if (irq_cause !== 6'h32) begin errors++; $display("FAIL prio_cause_fast2: got %h exp 32", irq_cause); end
      irq_ack = 1'b1; irq_fast[2] = 1'b0;
      step(1);
      irq_ack = 1'b0;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_ackd: got %b exp 0", irq_req); end
      step(2);
      checks++; if (irq_cause !== 6'h2B || irq_req !== 1'b1) begin errors++; $display("FAIL prio_cause_ext: got %h/%b exp 2b/1", irq_cause, irq_req); end
      irq_ack = 1'b1; irq_external = 1'b0;
      step(1);
      irq_ack = 1'b0;
      step(2);
      checks++; if (irq_cause !== 6'h23 || irq_req !== 1'b1) begin errors++; $display("FAIL prio_cause_sw: got %h/%b exp 23/1", irq_cause, irq_req); end
      irq_ack = 1'b1; irq_software = 1'b0;
      step(1);
      irq_ack = 1'b0;
      step(2);
   endtask

   task automatic test_nmi;
      mstatus_mie = 1'b0; mie = '0;
      irq_nm = 1'b1;
      step(1);
      irq_nm = 1'b0;
      step(1);
      checks++; if (irq_req !== 1'b1 || irq_cause !== 6'h3F) begin errors++; $display("FAIL nmi_req: got %b/%h exp 1/3f", irq_req, irq_cause); end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      checks++; if (nmi_mode !== 1'b1) begin errors++; $display("FAIL nmi_mode_set: got %b exp 1", nmi_mode); end
      step(1);
      irq_nm = 1'b1;
      step(1);
      irq_nm = 1'b0;
      step(4);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL nmi_nested_blocked: got %b exp 0", irq_req); end
      nmi_done = 1'b1;
      step(1);
      nmi_done = 1'b0;
      checks++; if (nmi_mode !== 1'b0) begin errors++; $display("FAIL nmi_mode_clear: got %b exp 0", nmi_mode); end
      step(1);
      checks++; if (irq_req !== 1'b1 || irq_cause !== 6'h3F) begin errors++; $display("FAIL nmi_req2: got %b/%h exp 1/3f", irq_req, irq_cause); end
      irq_ack = 1'b1; nmi_done = 1'b1;
      step(1);
      irq_ack = 1'b0; nmi_done = 1'b0;
      checks++; if (nmi_mode !== 1'b1) begin errors++; $display("FAIL nmi_ack_beats_done: got %b exp 1", nmi_mode); end
      step(1);
      nmi_done = 1'b1;
      step(1);
      nmi_done = 1'b0;
      step(2);
      checks++; if (irq_req !== 1'b0 || nmi_mode !== 1'b0) begin errors++; $display("FAIL nmi_idle_after: got %b/%b exp 0/0", irq_req, nmi_mode); end
   endtask

   task automatic test_withdraw;
      mstatus_mie = 1'b1; mie = 32'h0000_0080;
      irq_timer = 1'b1;
      step(2);
      checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL wd_req: got %b exp 1", irq_req); end
      mie = '0;
      step(1);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL wd_drop: got %b exp 0", irq_req); end
      step(2);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL wd_stay_idle: got %b exp 0", irq_req); end
      mie = 32'h0000_0080;
      step(1);
      checks++; if (irq_req !== 1'b1 || irq_cause !== 6'h27) begin errors++; $display("FAIL wd_rereq: got %b/%h exp 1/27", irq_req, irq_cause); end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0; irq_timer = 1'b0;
      step(2);
   endtask

   task automatic test_debug;
      mstatus_mie = 1'b1; mie = 32'h0000_0080;
      debug_mode = 1'b1; irq_timer = 1'b1;
      step(4);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL debug_suppress: got %b exp 0", irq_req); end
      debug_mode = 1'b0;
      step(1);
      checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL debug_release: got %b exp 1", irq_req); end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0; irq_timer = 1'b0;
      step(2);
   endtask

   task automatic test_back_to_back;
      logic [3:0] pat;
      mstatus_mie = 1'b1; mie = 32'h0000_0080;
      irq_timer = 1'b1; irq_ack = 1'b1;
      step(2);
      pat[3] = irq_req;
      step(1); pat[2] = irq_req;
      step(1); pat[1] = irq_req;
      step(1); pat[0] = irq_req;
      checks++; if (pat !== 4'b1001) begin errors++; $display("FAIL b2b_pattern: got %b exp 1001", pat); end
      irq_timer = 1'b0;
      step(3);
      irq_ack = 1'b0;
      step(1);
   endtask

   task automatic test_fast;
      mstatus_mie = 1'b1; mie = 32'h0008_0000;
`ifdef IBEX_IRQ_FAST_EDGE_EN
      irq_fast[3] = 1'b1;
      step(1);
      irq_fast[3] = 1'b0;
      step(1);
      checks++; if (csr_mip[19] !== 1'b1) begin errors++; $display("FAIL fast_edge_latch: got %b exp 1", csr_mip[19]); end
      checks++; if (irq_req !== 1'b1 || irq_cause !== 6'h33) begin errors++; $display("FAIL fast_edge_req: got %b/%h exp 1/33", irq_req, irq_cause); end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      checks++; if (csr_mip[19] !== 1'b0) begin errors++; $display("FAIL fast_edge_clear: got %b exp 0", csr_mip[19]); end
      step(2);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL fast_edge_no_rereq: got %b exp 0", irq_req); end
`else
      irq_fast[3] = 1'b1;
      step(1);
      checks++; if (csr_mip[19] !== 1'b1) begin errors++; $display("FAIL fast_level_mip: got %b exp 1", csr_mip[19]); end
      irq_fast[3] = 1'b0;
      step(1);
      checks++; if (csr_mip[19] !== 1'b0) begin errors++; $display("FAIL fast_level_mip_drop: got %b exp 0", csr_mip[19]); end
      checks++; if (irq_req !== 1'b1 || irq_cause !== 6'h33) begin errors++; $display("FAIL fast_level_req: got %b/%h exp 1/33", irq_req, irq_cause); end
      step(1);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL fast_level_withdraw: got %b exp 0", irq_req); end
`endif
      step(1);
   endtask

   task automatic test_reset_mid;
      mstatus_mie = 1'b1; mie = 32'h0000_0080;
      irq_timer = 1'b1;
      step(2);
      irq_nm = 1'b1;
      step(1);
      irq_nm = 1'b0;
      checks++; if (irq_req !== 1'b1 || irq_cause !== 6'h27) begin errors++; $display("FAIL rst_no_rearb: got %b/%h exp 1/27", irq_req, irq_cause); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (irq_req !== 1'b0 || irq_cause !== 6'h00) begin errors++; $display("FAIL rst_async_req: got %b/%h exp 0/00", irq_req, irq_cause); end
      checks++; if (csr_mip !== 32'h0 || nmi_mode !== 1'b0) begin errors++; $display("FAIL rst_async_state: got %h/%b exp 0/0", csr_mip, nmi_mode); end
      irq_timer = 1'b0;
      step(1);
      rst = 1'b0;
      step(4);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_nmi_lost: got %b exp 0", irq_req); end
   endtask

   initial begin
      test_reset();
      test_timer();
      test_priority();
      test_nmi();
      test_withdraw();
      test_debug();
      test_back_to_back();
      test_fast();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
